// File: rtl/id_operand_stage.sv
// id_operand_stage: decode-side operand fetch and ID/EX pipeline register.
//   Reads the two source operands from the register file and handles the
//   collision with a same-cycle writeback. It detects the load-use hazard
//   against the instruction already held in ID/EX, and drives a
//   valid/ready handshake toward EX. A saturating counter records the
//   cycles in which decode offers an instruction that this stage cannot
//   accept.
// Configuration macro: OPFWD_WB_BYPASS_EN
//   defined   : wb_rd is bypassed into a matching operand, with no stall.
//   undefined : the stage stalls one cycle until the register file holds
//               the new value.
// Ports:
//   clk, rst                     clock; asynchronous active-high reset
//   id_valid / id_ready          decode handshake
//   id_rs1Addr/id_rs2Addr/id_rdAddr, id_imm, id_ctrl, id_isLoad
//                                decoded instruction
//   rf_rs1Addr/rf_rs2Addr -> rf_rs1/rf_rs2
//                                register-file read port pair
//   wb_LoadRF, wb_rdAddr, wb_rd  writeback bus into the register file
//   ex_valid / ex_ready          execute handshake
//   ex_rs1, ex_rs2, ex_imm, ex_rdAddr, ex_ctrl, ex_isLoad
//                                registered ID/EX payload
//   flush                        kills the ID/EX contents
//   stall_cnt                    saturating count of stall cycles

// Per-operand select: zero register, writeback match, rf data.
module id_operand_sel (
  input  logic [4:0]  idx,
  input  logic [31:0] rf,
  input  logic        wb_LoadRF,
  input  logic [4:0]  wb_rdAddr,
  input  logic [31:0] wb_rd,
  output logic [31:0] op,
  output logic        wb_hit
);
  assign wb_hit = wb_LoadRF & (wb_rdAddr == idx) & (idx != 5'd0);
`ifdef OPFWD_WB_BYPASS_EN
  assign op = (idx == 5'd0) ? 32'h0 : (wb_hit ? wb_rd : rf);
`else
  // The stage stalls on wb_hit, so rf data is always current when it is used.
  logic unused_wb;
  assign unused_wb = ^wb_rd;
  assign op = (idx == 5'd0) ? 32'h0 : rf;
`endif
endmodule

module id_operand_stage #(
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [4:0]        id_rs1Addr,
  input  logic [4:0]        id_rs2Addr,
  input  logic [4:0]        id_rdAddr,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_isLoad,
  output logic [4:0]        rf_rs1Addr,
  output logic [4:0]        rf_rs2Addr,
  input  logic [31:0]       rf_rs1,
  input  logic [31:0]       rf_rs2,
  input  logic              wb_LoadRF,
  input  logic [4:0]        wb_rdAddr,
  input  logic [31:0]       wb_rd,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [31:0]       ex_rs1,
  output logic [31:0]       ex_rs2,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rdAddr,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_isLoad,
  input  logic              flush,
  output logic [15:0]       stall_cnt
);
  localparam int NUM_OPS = 2;

  logic [NUM_OPS-1:0][4:0]  src_idx;
  logic [NUM_OPS-1:0][31:0] rf_data;
  logic [NUM_OPS-1:0][31:0] op;
  logic [NUM_OPS-1:0]       wb_hit;
  logic                     hz_lu, hz_wb, advance, take;

  assign rf_rs1Addr = id_rs1Addr;
  assign rf_rs2Addr = id_rs2Addr;
  assign src_idx    = {id_rs2Addr, id_rs1Addr};
  assign rf_data    = {rf_rs2, rf_rs1};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    id_operand_sel u_sel (
      .idx      (src_idx[g]),
      .rf       (rf_data[g]),
      .wb_LoadRF(wb_LoadRF),
      .wb_rdAddr(wb_rdAddr),
      .wb_rd    (wb_rd),
      .op       (op[g]),
      .wb_hit   (wb_hit[g])
    );
  end

  // A load in ID/EX cannot feed its result to the next instruction. The
  // hazard clears once the load moves on, which gives exactly one bubble.
  assign hz_lu = ex_valid & ex_isLoad & (ex_rdAddr != 5'd0) &
                 ((ex_rdAddr == id_rs1Addr) | (ex_rdAddr == id_rs2Addr));

`ifdef OPFWD_WB_BYPASS_EN
  assign hz_wb = 1'b0;
`else
  assign hz_wb = |wb_hit;
`endif

  // ID/EX is free, or it is being drained on this edge. The second case
  // lets a new instruction enter on the same edge, giving full throughput.
  assign advance  = ~ex_valid | ex_ready;
  assign id_ready = ~rst & advance & ~hz_lu & ~hz_wb & ~flush;
  assign take     = id_valid & id_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_imm    <= '0;
      ex_rdAddr <= '0;
      ex_ctrl   <= '0;
      ex_isLoad <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (advance) begin
      ex_valid <= take;
      if (take) begin
        ex_rs1    <= op[0];
        ex_rs2    <= op[1];
        ex_imm    <= id_imm;
        ex_rdAddr <= id_rdAddr;
        ex_ctrl   <= id_ctrl;
        ex_isLoad <= id_isLoad;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (id_valid & ~id_ready & ~flush & (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
endmodule

// File: tb/tb_id_operand_stage.sv
module tb_id_operand_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_ready;
  logic [4:0]  id_rs1Addr, id_rs2Addr, id_rdAddr;
  logic [31:0] id_imm;
  logic [15:0] id_ctrl;
  logic        id_isLoad;
  logic [4:0]  rf_rs1Addr, rf_rs2Addr;
  logic [31:0] rf_rs1, rf_rs2;
  logic        wb_LoadRF;
  logic [4:0]  wb_rdAddr;
  logic [31:0] wb_rd;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_rs1, ex_rs2, ex_imm;
  logic [4:0]  ex_rdAddr;
  logic [15:0] ex_ctrl;
  logic        ex_isLoad;
  logic        flush;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  id_operand_stage #(.CTRL_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1Addr(id_rs1Addr), .id_rs2Addr(id_rs2Addr), .id_rdAddr(id_rdAddr),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .id_isLoad(id_isLoad),
    .rf_rs1Addr(rf_rs1Addr), .rf_rs2Addr(rf_rs2Addr),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .wb_LoadRF(wb_LoadRF), .wb_rdAddr(wb_rdAddr), .wb_rd(wb_rd),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
    .ex_rdAddr(ex_rdAddr), .ex_ctrl(ex_ctrl), .ex_isLoad(ex_isLoad),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [31:0] rs1, rs2, imm;
    logic [4:0]  rd;
    logic [15:0] ctrl;
    logic        ld;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_stall = 16'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_instr(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] imm, input logic [15:0] ctrl, input logic ld);
    id_rs1Addr = r1; id_rs2Addr = r2; id_rdAddr = rd;
    rf_rs1 = d1; rf_rs2 = d2; id_imm = imm; id_ctrl = ctrl; id_isLoad = ld;
    id_valid = 1'b1;
  endtask

  task automatic push_exp(input logic [31:0] o1, input logic [31:0] o2);
    exp_t e;
    e.rs1 = o1; e.rs2 = o2; e.imm = id_imm; e.rd = id_rdAddr;
    e.ctrl = id_ctrl; e.ld = id_isLoad;
    sb.push_back(e);
  endtask

  // One clock. Just before the edge, the bench scores what EX consumes and
  // drops what a flush kills. Sampling happens #1 after the edge.
  task automatic tick();
    exp_t e;
    if (flush) begin
      if (ex_valid && sb.size() > 0) void'(sb.pop_front());
    end else if (ex_valid && ex_ready) begin
      if (sb.size() == 0) chk("sb_unexpected", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("sb_rs1",  ex_rs1,  e.rs1);
        chk("sb_rs2",  ex_rs2,  e.rs2);
        chk("sb_imm",  ex_imm,  e.imm);
        chk("sb_rd",   {27'd0, ex_rdAddr}, {27'd0, e.rd});
        chk("sb_ctrl", {16'd0, ex_ctrl},   {16'd0, e.ctrl});
        chk("sb_ld",   {31'd0, ex_isLoad}, {31'd0, e.ld});
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    wb_LoadRF = 1'b0; wb_rdAddr = '0; wb_rd = '0;
    set_instr(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0, 1'b0);
    @(posedge clk); #1;
    chk("rst_ex_valid",  {31'd0, ex_valid}, 32'd0);
    chk("rst_id_ready",  {31'd0, id_ready}, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_ex_rs1",    ex_rs1, 32'd0);
    rst = 1'b0; id_valid = 1'b0; #1;
    chk("idle_id_ready", {31'd0, id_ready}, 32'd1);

    // Basic capture; rs2 = x0 forces a zero operand.
    set_instr(5'd5, 5'd0, 5'd3, 32'h11, 32'h55, 32'h1234, 16'hA5A5, 1'b0); #1;
    chk("rf_addr1", {27'd0, rf_rs1Addr}, 32'd5);
    push_exp(32'h11, 32'h0);
    tick();
    chk("basic_ex_valid", {31'd0, ex_valid}, 32'd1);
    id_valid = 1'b0;
    tick();
    chk("bubble_ex_valid", {31'd0, ex_valid}, 32'd0);

    // Writeback to the register being read.
    set_instr(5'd5, 5'd6, 5'd8, 32'h9, 32'h66, 32'h2, 16'h1, 1'b0);
    wb_LoadRF = 1'b1; wb_rdAddr = 5'd5; wb_rd = 32'hA; #1;
`ifdef OPFWD_WB_BYPASS_EN
    chk("wb_id_ready", {31'd0, id_ready}, 32'd1);
    push_exp(32'hA, 32'h66);
    tick();
    chk("wb_ex_valid", {31'd0, ex_valid}, 32'd1);
`else
    chk("wb_id_ready", {31'd0, id_ready}, 32'd0);
    tick();
    exp_stall++;
    chk("wb_bubble", {31'd0, ex_valid}, 32'd0);
    wb_LoadRF = 1'b0; rf_rs1 = 32'hA; #1;
    push_exp(32'hA, 32'h66);
    tick();
    chk("wb_ex_valid", {31'd0, ex_valid}, 32'd1);
`endif
    chk("wb_stall_cnt", {16'd0, stall_cnt}, {16'd0, exp_stall});
    wb_LoadRF = 1'b0; id_valid = 1'b0;
    tick();

    // Load-use: load to x7, the next instruction reads x7 through rs2.
    set_instr(5'd1, 5'd2, 5'd7, 32'h100, 32'h200, 32'h10, 16'h2, 1'b1);
    push_exp(32'h100, 32'h200);
    tick();
    set_instr(5'd3, 5'd7, 5'd9, 32'h300, 32'h777, 32'h20, 16'h3, 1'b0); #1;
    chk("lu_id_ready0", {31'd0, id_ready}, 32'd0);
    tick();
    exp_stall++;
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    chk("lu_stall_cnt", {16'd0, stall_cnt}, {16'd0, exp_stall});
    chk("lu_id_ready1", {31'd0, id_ready}, 32'd1);
    push_exp(32'h300, 32'h777);
    tick();
    chk("lu_capture", {31'd0, ex_valid}, 32'd1);

    // Backpressure for 3 cycles while decode offers the next instruction.
    ex_ready = 1'b0;
    set_instr(5'd10, 5'd11, 5'd12, 32'hA0A0, 32'hB0B0, 32'h30, 16'h4, 1'b0); #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_id_ready", {31'd0, id_ready}, 32'd0);
      tick();
      exp_stall++;
      chk("bp_ex_valid", {31'd0, ex_valid}, 32'd1);
      chk("bp_ex_rs1",   ex_rs1, 32'h300);
      chk("bp_ex_rd",    {27'd0, ex_rdAddr}, 32'd9);
      chk("bp_stall",    {16'd0, stall_cnt}, {16'd0, exp_stall});
    end
    ex_ready = 1'b1; #1;
    chk("tp_id_ready", {31'd0, id_ready}, 32'd1);
    push_exp(32'hA0A0, 32'hB0B0);
    tick();
    chk("tp_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("tp_ex_rs1", ex_rs1, 32'hA0A0);

    // Flush while EX stalls and decode offers an instruction.
    ex_ready = 1'b0; flush = 1'b1;
    set_instr(5'd13, 5'd14, 5'd15, 32'hC, 32'hD, 32'h40, 16'h5, 1'b0); #1;
    chk("fl_id_ready", {31'd0, id_ready}, 32'd0);
    tick();
    flush = 1'b0;
    chk("fl_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_stall", {16'd0, stall_cnt}, {16'd0, exp_stall});

    // Writeback to x0 with rs1 = x0: zero operand and no stall.
    ex_ready = 1'b1;
    set_instr(5'd0, 5'd4, 5'd16, 32'h1111, 32'h44, 32'h50, 16'h6, 1'b0);
    wb_LoadRF = 1'b1; wb_rdAddr = 5'd0; wb_rd = 32'hDEAD; #1;
    chk("x0_id_ready", {31'd0, id_ready}, 32'd1);
    push_exp(32'h0, 32'h44);
    tick();
    wb_LoadRF = 1'b0;
    chk("x0_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("x0_stall", {16'd0, stall_cnt}, {16'd0, exp_stall});

    // Saturation: hold backpressure until the counter pins at FFFF.
    ex_ready = 1'b0;
    set_instr(5'd1, 5'd1, 5'd1, 32'h1, 32'h1, 32'h0, 16'h0, 1'b0);
    for (int i = 0; i < 32'd65535 - {16'd0, exp_stall} - 2; i++) begin
      @(posedge clk);
    end
    #1;
    chk("sat_near", {16'd0, stall_cnt}, 32'h0000FFFD);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
    end
    #1;
    chk("sat_stall", {16'd0, stall_cnt}, 32'h0000FFFF);
    chk("sat_ex_rs1", ex_rs1, 32'h0);

    // Reset mid-operation discards ID/EX contents asynchronously.
    rst = 1'b1; #2;
    chk("mrst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("mrst_stall", {16'd0, stall_cnt}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0; ex_ready = 1'b1;
    set_instr(5'd2, 5'd3, 5'd4, 32'h22, 32'h33, 32'h60, 16'h7, 1'b0);
    push_exp(32'h22, 32'h33);
    tick();
    chk("post_rst_capture", {31'd0, ex_valid}, 32'd1);
    id_valid = 1'b0;
    tick();
    tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
